// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-bank slave: FSM encoding, fixed
// register indices/bits and bus-geometry helpers.
package apb_pkg;

   typedef enum logic [0:0] {
      IDLE_S   = 1'b0,
      ACCESS_S = 1'b1
   } apb_state_e;

   localparam int unsigned CTRL_IDX   = 0;
   localparam int unsigned STATUS_IDX = 1;
   localparam int unsigned START_BIT  = 0;
   localparam int unsigned BUSY_BIT   = 0;

   function automatic int unsigned strb_w(input int unsigned bus_width);
      return bus_width / 8;
   endfunction

   function automatic int unsigned addr_lsb(input int unsigned bus_width);
      return $clog2(bus_width / 8);
   endfunction

endpackage

// File: rtl/apb_byte_reg.sv
// One bus-wide register with per-byte write enables and a synchronous clear.
module apb_byte_reg #(
   parameter int unsigned BUS_WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     clr_i,
   input  logic [BUS_WIDTH/8-1:0]   we_i,
   input  logic [BUS_WIDTH-1:0]     d_i,
   output logic [BUS_WIDTH-1:0]     q_o
);

   logic [BUS_WIDTH-1:0] r_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         r_q <= '0;
      end else begin
         for (int b = 0; b < BUS_WIDTH / 8; b++) begin
            if (we_i[b]) begin
               r_q[8*b +: 8] <= d_i[8*b +: 8];
            end
         end
      end
   end

   assign q_o = r_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register bank for the matmul accelerator. Index 0 is control with a
// self-clearing start bit, index 1 mirrors the core status, the rest are plain R/W.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned BUS_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          psel_i,
   input  logic                          penable_i,
   input  logic                          pwrite_i,
   input  logic [strb_w(BUS_WIDTH)-1:0]  pstrb_i,
   input  logic [BUS_WIDTH-1:0]          pwdata_i,
   input  logic [ADDR_WIDTH-1:0]         paddr_i,
   output logic                          pready_o,
   output logic                          pslverr_o,
   output logic [BUS_WIDTH-1:0]          prdata_o,
   input  logic [BUS_WIDTH-1:0]          status_i,
   output logic                          start_o,
   output logic [NUM_REGS*BUS_WIDTH-1:0] regs_o
);

   localparam int unsigned STRB_W   = strb_w(BUS_WIDTH);
   localparam int unsigned ADDR_LSB = addr_lsb(BUS_WIDTH);
   localparam int unsigned IDX_W    = $clog2(NUM_REGS);

   localparam logic [3:0]            WS_CNT     = 4'(WAIT_STATES);
   localparam logic [63:0]           BANK_BYTES = 64'(NUM_REGS * STRB_W);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);
   localparam logic [BUS_WIDTH-1:0]  START_MASK = {{(BUS_WIDTH-1){1'b0}}, 1'b1} << START_BIT;

   apb_state_e           r_state, w_state_nxt;
   logic [3:0]           r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]     r_idx, w_idx;
   logic                 r_write;
   logic                 r_err;
   logic [BUS_WIDTH-1:0] r_prdata;
   logic                 r_start, w_start_nxt;

   logic w_setup, w_ready, w_commit;
   logic w_misaligned, w_oor, w_ro, w_busy, w_err;

   logic [BUS_WIDTH-1:0] w_bank [NUM_REGS];

   // Address/attribute decode, captured at the setup edge.
   always_comb begin
      w_idx        = paddr_i[ADDR_LSB +: IDX_W];
      w_misaligned = (paddr_i & ADDR_MASK) != '0;
      w_oor        = 64'(paddr_i) >= BANK_BYTES;
      w_ro         = pwrite_i & (w_idx == IDX_W'(STATUS_IDX));
      w_busy       = pwrite_i & (w_idx == IDX_W'(CTRL_IDX)) & status_i[BUSY_BIT];
      w_err        = w_misaligned | w_oor | w_ro | w_busy;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_setup     = 1'b0;
      w_ready     = 1'b0;
      w_commit    = 1'b0;
      unique case (r_state)
         IDLE_S: begin
            if (psel_i && !penable_i) begin
               w_setup     = 1'b1;
               w_state_nxt = ACCESS_S;
               w_cnt_nxt   = '0;
            end
         end
         ACCESS_S: begin
            if (!(psel_i && penable_i)) begin
               w_state_nxt = IDLE_S;
               w_cnt_nxt   = '0;
            end else if (r_cnt == WS_CNT) begin
               // Reset in the completing cycle suppresses the handshake and the write.
               w_ready     = ~rst_i;
               w_commit    = ~rst_i & r_write & ~r_err;
               w_state_nxt = IDLE_S;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE_S;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_start_nxt = w_commit & (r_idx == IDX_W'(CTRL_IDX)) &
                        pstrb_i[START_BIT/8] & pwdata_i[START_BIT];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE_S;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_write  <= 1'b0;
         r_err    <= 1'b0;
         r_prdata <= '0;
         r_start  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_start <= w_start_nxt;
         if (w_setup) begin
            r_idx    <= w_idx;
            r_write  <= pwrite_i;
            r_err    <= w_err;
            r_prdata <= w_err ? '0 : w_bank[w_idx];
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_bank
      if (k == STATUS_IDX) begin : g_status
         assign w_bank[k] = status_i;
      end else begin : g_reg
         logic [STRB_W-1:0]    w_we;
         logic [BUS_WIDTH-1:0] w_d;

         assign w_we = (w_commit && (r_idx == IDX_W'(k))) ? pstrb_i : '0;
         // The start bit is never stored so the control word always reads it as 0.
         assign w_d  = (k == CTRL_IDX) ? (pwdata_i & ~START_MASK) : pwdata_i;

         apb_byte_reg #(
            .BUS_WIDTH (BUS_WIDTH)
         ) u_reg (
            .clk_i (clk_i),
            .clr_i (rst_i),
            .we_i  (w_we),
            .d_i   (w_d),
            .q_o   (w_bank[k])
         );
      end
      assign regs_o[k*BUS_WIDTH +: BUS_WIDTH] = w_bank[k];
   end

   assign pready_o  = w_ready;
   assign pslverr_o = w_ready & r_err;
   assign prdata_o  = r_prdata;
   assign start_o   = r_start;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Drives one shared APB bus into a zero-wait and a three-wait slave and checks both
// every cycle against a transaction-level model of the register bank.
module tb_apb_slave_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [7:0]  pstrb = '0;
   logic [63:0] pwdata = '0;
   logic [31:0] paddr = '0;
   logic [63:0] status = '0;

   logic        pready  [2];
   logic        pslverr [2];
   logic        start   [2];
   logic [63:0] prdata  [2];
   logic [511:0] regs   [2];

   always #5 clk = ~clk;

   apb_slave_regfile #(
      .BUS_WIDTH (64), .ADDR_WIDTH (32), .NUM_REGS (8), .WAIT_STATES (0)
   ) u_dut0 (
      .clk_i (clk), .rst_i (rst), .psel_i (psel), .penable_i (penable),
      .pwrite_i (pwrite), .pstrb_i (pstrb), .pwdata_i (pwdata), .paddr_i (paddr),
      .pready_o (pready[0]), .pslverr_o (pslverr[0]), .prdata_o (prdata[0]),
      .status_i (status), .start_o (start[0]), .regs_o (regs[0])
   );

   apb_slave_regfile #(
      .BUS_WIDTH (64), .ADDR_WIDTH (32), .NUM_REGS (8), .WAIT_STATES (3)
   ) u_dut3 (
      .clk_i (clk), .rst_i (rst), .psel_i (psel), .penable_i (penable),
      .pwrite_i (pwrite), .pstrb_i (pstrb), .pwdata_i (pwdata), .paddr_i (paddr),
      .pready_o (pready[1]), .pslverr_o (pslverr[1]), .prdata_o (prdata[1]),
      .status_i (status), .start_o (start[1]), .regs_o (regs[1])
   );

   int n_vec = 0;
   int n_err = 0;
   int ws_of [2] = '{0, 3};

   // Model: one open transfer per slave plus the bank contents.
   bit          m_open   [2];
   int          m_age    [2];
   int          m_idx    [2];
   bit          m_wr     [2];
   bit          m_err    [2];
   logic [63:0] m_prdata [2];
   logic [63:0] m_bank   [2][8];
   bit          m_start  [2];

   // Per-transfer observations for the literal checks.
   int          phase;
   int          rdy_n  [2];
   int          rdy_at [2];
   int          st_n   [2];
   logic        err_seen [2];
   logic [63:0] rd_seen  [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready(input int d);
      return m_open[d] && psel && penable && (m_age[d] == ws_of[d]) && !rst;
   endfunction

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit rdy;
         bit nstart;
         rdy    = exp_ready(d);
         nstart = 1'b0;
         if (rst) begin
            m_open[d]   = 1'b0;
            m_age[d]    = 0;
            m_prdata[d] = '0;
            m_start[d]  = 1'b0;
            for (int k = 0; k < 8; k++) m_bank[d][k] = '0;
         end else begin
            if (m_open[d]) begin
               if (!(psel && penable)) begin
                  m_open[d] = 1'b0;
               end else if (rdy) begin
                  if (m_wr[d] && !m_err[d]) begin
                     for (int b = 0; b < 8; b++)
                        if (pstrb[b]) m_bank[d][m_idx[d]][8*b +: 8] = pwdata[8*b +: 8];
                     if (m_idx[d] == 0) begin
                        nstart = pstrb[0] && pwdata[0];
                        m_bank[d][0][0] = 1'b0;
                     end
                  end
                  m_open[d] = 1'b0;
               end else begin
                  m_age[d]++;
               end
            end else if (psel && !penable) begin
               int unsigned a;
               a           = paddr;
               m_idx[d]    = int'((a / 8) % 8);
               m_wr[d]     = pwrite;
               m_err[d]    = (a % 8 != 0) || (a >= 64) || (pwrite && m_idx[d] == 1) ||
                             (pwrite && m_idx[d] == 0 && status[0]);
               m_prdata[d] = m_err[d] ? 64'h0 : (m_idx[d] == 1 ? status : m_bank[d][m_idx[d]]);
               m_open[d]   = 1'b1;
               m_age[d]    = 0;
            end
            m_start[d] = nstart;
         end
      end
   endtask

   // Compare at the falling edge, then advance the model for the coming rising edge.
   task automatic cycle();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         bit er;
         er = exp_ready(d);
         check($sformatf("pready[%0d]", d), 64'(pready[d]), 64'(er));
         check($sformatf("pslverr[%0d]", d), 64'(pslverr[d]), 64'(er && m_err[d]));
         check($sformatf("prdata[%0d]", d), prdata[d], m_prdata[d]);
         check($sformatf("start[%0d]", d), 64'(start[d]), 64'(m_start[d]));
         for (int k = 0; k < 8; k++)
            check($sformatf("regs[%0d][%0d]", d, k), regs[d][k*64 +: 64],
                  (k == 1) ? status : m_bank[d][k]);
         if (pready[d] === 1'b1) begin
            rdy_n[d]++;
            rdy_at[d]   = phase;
            err_seen[d] = pslverr[d];
            rd_seen[d]  = prdata[d];
         end
         if (start[d] === 1'b1) st_n[d]++;
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      for (int d = 0; d < 2; d++) begin
         rdy_n[d] = 0; rdy_at[d] = -1; st_n[d] = 0; err_seen[d] = 1'bx; rd_seen[d] = 'x;
      end
   endtask

   task automatic idle(input int n);
      psel = 1'b0; penable = 1'b0; phase = -1;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [63:0] data,
                       input logic [7:0] strb, input int hold, input int rst_at);
      clear_obs();
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      phase = 0;
      cycle();
      for (int i = 1; i <= hold; i++) begin
         penable = 1'b1; rst = (i == rst_at); phase = i;
         cycle();
      end
      rst = 1'b0;
   endtask

   task automatic expect_done(input string name, input int d, input int at,
                              input logic err, input logic [63:0] rd, input bit chk_rd);
      check({name, "_rdy_n"}, 64'(rdy_n[d]), 64'd1);
      check({name, "_rdy_at"}, 64'(rdy_at[d]), 64'(at));
      check({name, "_err"}, 64'(err_seen[d]), 64'(err));
      if (chk_rd) check({name, "_rdata"}, rd_seen[d], rd);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_open[d] = 0; m_age[d] = 0; m_idx[d] = 0; m_wr[d] = 0; m_err[d] = 0;
         m_prdata[d] = '0; m_start[d] = 0;
         for (int k = 0; k < 8; k++) m_bank[d][k] = '0;
      end
      clear_obs();
      phase = -1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      check("rst_prdata", prdata[0], 64'h0);
      check("rst_start", 64'(start[0]), 64'h0);
      check("rst_pready", 64'(pready[1]), 64'h0);
      check("rst_slot2", regs[1][2*64 +: 64], 64'h0);

      // Full write then back-to-back read of index 2.
      xfer(1'b1, 32'h10, 64'hDEADBEEF_01234567, 8'hFF, 4, 0);
      expect_done("wr10_d0", 0, 1, 1'b0, 64'h0, 1'b0);
      expect_done("wr10_d3", 1, 4, 1'b0, 64'h0, 1'b0);
      xfer(1'b0, 32'h10, 64'h0, 8'h00, 4, 0);
      expect_done("rd10_d0", 0, 1, 1'b0, 64'hDEADBEEF_01234567, 1'b1);
      expect_done("rd10_d3", 1, 4, 1'b0, 64'hDEADBEEF_01234567, 1'b1);

      // Low-half strobes over a zero word.
      xfer(1'b1, 32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4, 0);
      xfer(1'b0, 32'h18, 64'h0, 8'h00, 4, 0);
      expect_done("rd18_d0", 0, 1, 1'b0, 64'h00000000_FFFFFFFF, 1'b1);
      expect_done("rd18_d3", 1, 4, 1'b0, 64'h00000000_FFFFFFFF, 1'b1);

      // Start pulse, then the same write while the core is busy.
      status = 64'h0;
      xfer(1'b1, 32'h00, 64'h1, 8'hFF, 4, 0);
      idle(2);
      check("start_pulse_d0", 64'(st_n[0]), 64'd1);
      check("start_pulse_d3", 64'(st_n[1]), 64'd1);
      xfer(1'b0, 32'h00, 64'h0, 8'h00, 4, 0);
      expect_done("rd00_d0", 0, 1, 1'b0, 64'h0, 1'b1);
      status = 64'h1;
      xfer(1'b1, 32'h00, 64'h1, 8'hFF, 4, 0);
      idle(2);
      check("busy_err_d0", 64'(err_seen[0]), 64'd1);
      check("busy_err_d3", 64'(err_seen[1]), 64'd1);
      check("busy_nostart_d0", 64'(st_n[0]), 64'd0);
      status = 64'h0;

      // Error writes: status slot, misaligned, out of range.
      xfer(1'b1, 32'h08, 64'h5555, 8'hFF, 4, 0);
      expect_done("wr08_d0", 0, 1, 1'b1, 64'h0, 1'b0);
      xfer(1'b1, 32'h04, 64'h5555, 8'hFF, 4, 0);
      expect_done("wr04_d3", 1, 4, 1'b1, 64'h0, 1'b0);
      xfer(1'b1, 32'h40, 64'h5555, 8'hFF, 4, 0);
      expect_done("wr40_d0", 0, 1, 1'b1, 64'h0, 1'b0);
      check("err_keep_slot0", regs[0][0 +: 64], 64'h0);
      check("err_keep_slot2", regs[0][2*64 +: 64], 64'hDEADBEEF_01234567);
      status = 64'h12345678_9ABCDEF0;
      xfer(1'b0, 32'h08, 64'h0, 8'h00, 4, 0);
      expect_done("rd08_d3", 1, 4, 1'b0, 64'h12345678_9ABCDEF0, 1'b1);
      status = 64'h0;

      // psel dropped after two access cycles: only the zero-wait slave completes.
      xfer(1'b1, 32'h20, 64'hCAFE_F00D_1111_2222, 8'hFF, 2, 0);
      idle(1);
      check("abort_nordy_d3", 64'(rdy_n[1]), 64'd0);
      check("abort_slot4_d3", regs[1][4*64 +: 64], 64'h0);
      check("abort_slot4_d0", regs[0][4*64 +: 64], 64'hCAFE_F00D_1111_2222);
      xfer(1'b0, 32'h20, 64'h0, 8'h00, 4, 0);
      expect_done("rd20_d3", 1, 4, 1'b0, 64'h0, 1'b1);

      // Reset during the first access cycle of a start write.
      xfer(1'b1, 32'h00, 64'h0F01, 8'hFF, 1, 1);
      idle(2);
      check("rstmid_nordy_d0", 64'(rdy_n[0]), 64'd0);
      check("rstmid_nostart_d0", 64'(st_n[0]), 64'd0);
      check("rstmid_slot0_d0", regs[0][0 +: 64], 64'h0);
      check("rstmid_slot2_d0", regs[0][2*64 +: 64], 64'h0);

      // Randomised traffic, including aborts, missing setups and stray resets.
      for (int t = 0; t < 250; t++) begin
         int          r;
         int          hold;
         int          rat;
         logic [31:0] a;
         r = int'($urandom_range(0, 9));
         if (r <= 6)      a = 32'($urandom_range(0, 7) * 8);
         else if (r == 7) a = 32'($urandom_range(0, 7) * 8 + $urandom_range(1, 7));
         else if (r == 8) a = 32'h40 + ($urandom & 32'hFFF8);
         else             a = 32'($urandom_range(0, 1) * 8);
         status = {$urandom, $urandom};
         hold   = int'($urandom_range(1, 5));
         rat    = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, hold)) : 0;
         xfer(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), hold, rat);
         case ($urandom_range(0, 3))
            0: ;
            1: idle(1);
            2: idle(2);
            default: begin
               psel = 1'b1; penable = 1'b1; phase = -1;
               cycle();
            end
         endcase
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- Parametrised APB slave for the matmul accelerator: bus-side register bank with a SETUP/ACCESS handshake, configurable wait states, byte-strobed writes and error signalling.
- Sits between the APB interconnect and the matmul core.
- Exports a control register with a start pulse, takes status read-only from the core, and holds NUM_REGS-2 general R/W operand/config words.

Parameters:
- BUS_WIDTH, 64, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 32, APB address width.
- NUM_REGS, 8, word registers in the bank; power of 2, >= 4.
- WAIT_STATES, 0, extra ACCESS cycles before pready_o; 0..15.
- Derived: STRB_W = BUS_WIDTH/8; ADDR_LSB = log2(STRB_W); IDX_W = log2(NUM_REGS).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1 = write, 0 = read.
- pstrb_i  in  STRB_W  byte-lane write strobes.
- pwdata_i  in  BUS_WIDTH  write data.
- paddr_i  in  ADDR_WIDTH  byte address.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error; valid only with pready_o.
- prdata_o  out  BUS_WIDTH  read data; valid with pready_o on reads.
- status_i  in  BUS_WIDTH  core status, read-only at index 1; bit0 = busy.
- start_o  out  1  one-cycle start pulse to the core.
- regs_o  out  NUM_REGS*BUS_WIDTH  flattened bank; index k at [k*BUS_WIDTH +: BUS_WIDTH]; slot 1 = status_i.

Behaviour:
- Reset (rst_i high at posedge): state IDLE, wait counter 0, all bank words 0, prdata_o 0, start_o 0. Combinational pready_o and pslverr_o read 0 in IDLE.
- Reset mid-transfer: the transfer is abandoned, no register is written, and no pready_o is issued.
- FSM states: IDLE and ACCESS.
  - IDLE -> ACCESS when psel_i=1 and penable_i=0 (setup phase) at posedge. Address, direction and error are decoded and latched at that edge.
  - psel_i=1 with penable_i=1 while in IDLE (missing setup) is ignored; state stays IDLE.
  - In ACCESS:
    - Wait counter increments each cycle until it reaches WAIT_STATES.
    - pready_o = (state==ACCESS) & (cnt==WAIT_STATES) & psel_i & penable_i.
    - At the posedge where pready_o=1: commit the write (if any), clear cnt, return to IDLE.
    - Back-to-back transfers are allowed: the next setup phase is the cycle after pready.
  - Abort: psel_i=0 or penable_i=0 while in ACCESS -> IDLE next cycle, no write, cnt cleared.
- Latency: WAIT_STATES=0 gives the standard 2-cycle transfer. pready_o is high in the first access cycle. Each wait state adds 1 cycle.
- Decode:
  - idx = paddr_i[ADDR_LSB +: IDX_W].
  - Error if paddr_i[ADDR_LSB-1:0] != 0 (misaligned) or paddr_i >= NUM_REGS*STRB_W (out of range).
  - Error if the transfer is a write to idx 1 (read-only status).
  - Error if the transfer is a write to idx 0 while status_i[0]=1 (core busy).
  - pslverr_o = latched error & pready_o. An errored transfer writes nothing; an errored read returns prdata_o = 0.
- Read: prdata_o is loaded at the IDLE->ACCESS edge with bank[idx] (idx 1 -> status_i) and holds until the next load.
- Write: for each byte lane b with pstrb_i[b]=1, bank[idx][8b+7:8b] <= pwdata_i lane b. Lanes with pstrb_i[b]=0 are unchanged. pstrb_i=0 is a legal no-op write with no error.
- Start: a committed write to idx 0 with pstrb_i[0]=1 and pwdata_i[0]=1 makes start_o=1 for exactly the next cycle. Bank[0] bit0 is self-clearing and always reads 0. Other idx-0 bits hold their written value.
- The core's status_i is sampled live; no synchronisation is needed (same clock).

Decomposition:
- Shared package apb_pkg holds the FSM state encoding (IDLE_S, ACCESS_S), CTRL_IDX=0, STATUS_IDX=1, START_BIT=0, BUSY_BIT=0, and STRB_W/ADDR_LSB helper functions.
- One natural sub-module: apb_byte_reg. It is a single BUS_WIDTH register with per-byte write enable and a synchronous active-high clear, instantiated NUM_REGS-1 times (all indices except 1).

Test Plan:
- Reset, then write 0xDEADBEEF_01234567 to addr 0x10 with pstrb=0xFF (WAIT_STATES=0), then read addr 0x10 -> pready_o high on the 2nd transfer cycle, pslverr_o=0, prdata_o=0xDEADBEEF_01234567.
- Write 0xFFFF_FFFF_FFFF_FFFF to addr 0x18 with pstrb=0x0F over a prior value of 0 -> read returns 0x00000000_FFFFFFFF.
- Write 0x1 to addr 0x00 with status_i=0 -> start_o=1 for exactly one cycle and a read of addr 0 returns 0. Repeat with status_i=1 -> pslverr_o=1 and start_o stays 0.
- Write to addr 0x08 (status), to addr 0x04 (misaligned) and to addr 0x40 (out of range, NUM_REGS=8) -> pslverr_o=1 on each and the bank is unchanged. A read of 0x08 returns the current status_i value.
- WAIT_STATES=3: a read takes 5 cycles with pready_o high only in the last. A write aborted by dropping psel_i in cycle 3 -> no pready, no write, and the FSM returns to IDLE.
- Assert rst_i during the ACCESS cycle of a write -> the register keeps its old value (0 after reset), and pready_o and start_o stay 0.
